// File: rtl/trigger_generator_pkg.sv
// Shared types and defaults for the trigger pulse generator.
package trigger_generator_pkg;

   localparam int unsigned WIDTH_W_DEFAULT = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

endpackage

// File: rtl/trigger_generator_edge_detect.sv
// Rising-edge detector for the trigger request. The history flop resets to 1
// so a request already high when reset releases is not taken as an edge.
module trig_edge_detect (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_evt
);

   logic sig_d;
   logic sig_q;

   always_comb begin
      sig_d = i_sig;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sig_q <= 1'b1;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign o_evt = i_sig & ~sig_q;

endmodule

// File: rtl/trigger_generator.sv
// Edge-triggered pulse generator with programmable width and active level.
// Define TRIG_RETRIGGER_EN to let a trigger during a pulse reload it.
module trigger_generator
   import trigger_generator_pkg::*;
#(
   parameter int unsigned WIDTH_W = WIDTH_W_DEFAULT
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic               i_out_level,
   input  logic [WIDTH_W-1:0] i_width,
   output logic               o_trig,
   output logic               o_busy
);

   logic               trig_evt;
   logic               width_nz;

   state_e             state_d, state_q;
   logic [WIDTH_W-1:0] cnt_d, cnt_q;
   logic               lvl_d, lvl_q;
   logic               trig_d, trig_q;
   logic               busy_d, busy_q;

   trig_edge_detect u_edge (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_sig (i_en),
      .o_evt (trig_evt)
   );

   assign width_nz = (i_width != '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      trig_d  = trig_q;
      busy_d  = busy_q;

      unique case (state_q)
         IDLE: begin
            if (trig_evt && width_nz) begin
               state_d = ACTIVE;
               cnt_d   = i_width;
               lvl_d   = i_out_level;
               trig_d  = i_out_level;
               busy_d  = 1'b1;
            end else begin
               cnt_d  = '0;
               trig_d = ~i_out_level;
               busy_d = 1'b0;
            end
         end

         ACTIVE: begin
`ifdef TRIG_RETRIGGER_EN
            if (trig_evt) begin
               if (width_nz) begin
                  cnt_d  = i_width;
                  lvl_d  = i_out_level;
                  trig_d = i_out_level;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  trig_d  = ~i_out_level;
                  busy_d  = 1'b0;
               end
            end else
`endif
            // Counter at 1 marks the final active cycle; a trigger here chains directly.
            if (cnt_q == WIDTH_W'(1)) begin
               if (trig_evt && width_nz) begin
                  cnt_d  = i_width;
                  lvl_d  = i_out_level;
                  trig_d = i_out_level;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  trig_d  = ~i_out_level;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d  = cnt_q - WIDTH_W'(1);
               trig_d = lvl_q;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            trig_d  = ~i_out_level;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         trig_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         trig_q  <= trig_d;
         busy_q  <= busy_d;
      end
   end

   assign o_trig = trig_q;
   assign o_busy = busy_q;

endmodule

// File: tb/tb_trigger_generator.sv
// Self-checking bench for trigger_generator: a cycle model pushes expected
// outputs per driven cycle, popped and compared one edge later.
module tb_trigger_generator;

   localparam int unsigned WW = 4;

   typedef struct {
      logic trig;
      logic busy;
   } exp_t;

   logic          i_clk;
   logic          i_rst;
   logic          i_en;
   logic          i_out_level;
   logic [WW-1:0] i_width;
   logic          o_trig;
   logic          o_busy;

   int total;
   int bad;

   exp_t exp_q[$];

   // reference model state
   int   m_left;
   logic m_prev_en;
   logic m_lvl;

   trigger_generator #(.WIDTH_W(WW)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_en        (i_en),
      .i_out_level (i_out_level),
      .i_width     (i_width),
      .o_trig      (o_trig),
      .o_busy      (o_busy)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d at t=%0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_left    = 0;
      m_prev_en = 1'b1;
      m_lvl     = 1'b0;
   endtask

   // Expected outputs after the edge that samples (en, w, l).
   function automatic exp_t model_step(input logic en, input int w, input logic l);
      exp_t e;
      logic ev;
      logic retrig;
      ev = en && !m_prev_en;
      m_prev_en = en;
`ifdef TRIG_RETRIGGER_EN
      retrig = ev && (m_left >= 1);
`else
      retrig = 1'b0;
`endif
      if (retrig) begin
         if (w != 0) begin
            m_left = w; m_lvl = l; e.trig = l; e.busy = 1'b1;
         end else begin
            m_left = 0; e.trig = !l; e.busy = 1'b0;
         end
      end else if (m_left > 1) begin
         m_left--; e.trig = m_lvl; e.busy = 1'b1;
      end else if (ev && w != 0) begin
         m_left = w; m_lvl = l; e.trig = l; e.busy = 1'b1;
      end else begin
         m_left = 0; e.trig = !l; e.busy = 1'b0;
      end
      return e;
   endfunction

   task automatic step(input string tag, input logic en, input int w, input logic l);
      exp_t e;
      @(negedge i_clk);
      i_en        = en;
      i_width     = WW'(w);
      i_out_level = l;
      exp_q.push_back(model_step(en, w, l));
      @(posedge i_clk);
      #1;
      if (exp_q.size() == 0) begin
         check_eq({tag, "_queue"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         check_eq({tag, "_trig"}, int'(o_trig), int'(e.trig));
         check_eq({tag, "_busy"}, int'(o_busy), int'(e.busy));
      end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      i_rst       = 1'b1;
      i_en        = 1'b0;
      i_out_level = 1'b1;
      i_width     = '0;
      model_reset();

      repeat (2) @(posedge i_clk);
      #1;
      check_eq("rst_trig", int'(o_trig), 0);
      check_eq("rst_busy", int'(o_busy), 0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // idle level follows complement of i_out_level
      repeat (3) step("idle_hi", 1'b0, 10, 1'b1);
      repeat (2) step("idle_lo", 1'b0, 10, 1'b0);

      // width 10, active high, request held high
      repeat (2) step("w10_pre", 1'b0, 10, 1'b1);
      repeat (15) step("w10_held", 1'b1, 10, 1'b1);
      repeat (2) step("w10_post", 1'b0, 10, 1'b1);

      // width 3, active low, single-cycle request
      repeat (2) step("w3_pre", 1'b0, 3, 1'b0);
      step("w3_edge", 1'b1, 3, 1'b0);
      repeat (5) step("w3_run", 1'b0, 3, 1'b0);

      // zero width ignored
      step("w0_edge", 1'b1, 0, 1'b1);
      repeat (3) step("w0_run", 1'b0, 0, 1'b1);

      // width/level changes mid-pulse, plus a second request at cycle 2
      step("chg_edge", 1'b1, 4, 1'b1);
      step("chg_c1", 1'b0, 15, 1'b0);
      step("chg_c2", 1'b1, 4, 1'b0);
      repeat (6) step("chg_run", 1'b0, 15, 1'b0);

      // requests spaced exactly one width apart chain without a gap
      repeat (3) begin
         step("b2b_edge", 1'b1, 5, 1'b1);
         repeat (4) step("b2b_run", 1'b0, 5, 1'b1);
      end
      repeat (3) step("b2b_tail", 1'b0, 5, 1'b1);

      // maximum width
      step("max_edge", 1'b1, 15, 1'b0);
      repeat (17) step("max_run", 1'b0, 15, 1'b0);

      // reset mid-pulse with request held high through release
      step("rstp_edge", 1'b1, 8, 1'b1);
      step("rstp_c1", 1'b1, 8, 1'b1);
      #2;
      i_rst = 1'b1;
      #1;
      check_eq("rstp_async_trig", int'(o_trig), 0);
      check_eq("rstp_async_busy", int'(o_busy), 0);
      model_reset();
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (4) step("rstp_after", 1'b1, 8, 1'b1);
      repeat (2) step("rstp_low", 1'b0, 8, 1'b1);
      step("rstp_new", 1'b1, 2, 1'b1);
      repeat (3) step("rstp_new_run", 1'b0, 2, 1'b1);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
      end

      check_eq("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
